// File: rtl/edp_diag_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : edp_diag_reader_if
// Description : EBUS diagnostic handshake bundle between the diagnostic
//               reader (master) and the EBUS arbiter / EDP side (slave).
//               Bit numbering of ebusData is PDP-10 style: bit 0 = MSB.
// Revision    : 1.0 - initial release
// ============================================================================
interface edp_diag_reader_if;
    logic        ebusReq;
    logic        ebusGrant;
    logic        diagReadFunc12x;
    logic [2:0]  diagSel;
    logic [0:35] ebusData;
    logic        ebusParity;

    modport master (
        output ebusReq,
        output diagReadFunc12x,
        output diagSel,
        input  ebusGrant,
        input  ebusData,
        input  ebusParity
    );

    modport slave (
        input  ebusReq,
        input  diagReadFunc12x,
        input  diagSel,
        output ebusGrant,
        output ebusData,
        output ebusParity
    );
endinterface
`default_nettype wire

// File: rtl/edp_diag_reader.sv
`default_nettype none
// ============================================================================
// Module      : edp_diag_reader
// Description : Console-side diagnostic EBUS reader. On one start pulse it
//               arbitrates for the EBUS, then steps DIAG read function 12x
//               through the selected codes (AR, BR, MQ, FM, BRX, ARX, ADX,
//               AD), letting the bus settle before capturing each 36-bit
//               word into an 8-entry buffer that the console reads back.
//               Optional feature macro: EDP_DIAG_PARITY_EN (odd-parity
//               checking of each captured word).
// Revision    : 1.0 - initial release
// ============================================================================
module edp_diag_reader #(
    parameter int SETTLE_CYCLES = 2,   // 1..15
    parameter int GRANT_TIMEOUT = 255  // 1..1023
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          start,
    input  wire  [0:7]   regMask,
    edp_diag_reader_if.master ebus,
    output logic         busy,
    output logic         done,
    output logic         timeout,
    output logic [0:7]   validMask,
    input  wire  [2:0]   rdAddr,
    output logic [0:35]  rdData
`ifdef EDP_DIAG_PARITY_EN
    ,
    output logic         parityErr,
    output logic [0:7]   parityMask
`endif
);

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_REQ     = 3'd1;
    localparam logic [2:0] c_S_DRIVE   = 3'd2;
    localparam logic [2:0] c_S_CAPTURE = 3'd3;
    localparam logic [2:0] c_S_FINISH  = 3'd4;

    localparam logic [3:0] c_SETTLE    = 4'(SETTLE_CYCLES);
    localparam logic [9:0] c_GRANT_TO  = 10'(GRANT_TIMEOUT);

    logic [2:0]  r_state;
    logic [0:7]  r_pending;
    logic [9:0]  r_gcnt;
    logic [3:0]  r_scnt;
    logic        r_ebus_req;
    logic        r_func;
    logic [2:0]  r_sel;
    logic        r_busy;
    logic        r_done;
    logic        r_timeout;
    logic [0:7]  r_valid;
    logic [0:35] r_buf [0:7];

    logic [0:7]  w_pend_after;
    logic [9:0]  w_gcnt_next;
    logic        w_cap_we;

    // Lowest-numbered set bit of a select mask (bit 0 = AR has priority).
    function automatic logic [2:0] f_lowest(input logic [0:7] m);
        logic [2:0] v;
        v = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) v = 3'(k);
        end
        return v;
    endfunction

    // Pending selects once the word currently on the bus has been captured.
    always_comb begin
        w_pend_after        = r_pending;
        w_pend_after[r_sel] = 1'b0;
    end

    assign w_gcnt_next = r_gcnt + 10'd1;
    assign w_cap_we    = (r_state == c_S_CAPTURE);

`ifdef EDP_DIAG_PARITY_EN
    logic       r_perr;
    logic [0:7] r_pmask;
    logic       w_par_bad;
    // Data plus parity bit must carry an odd number of ones.
    assign w_par_bad = ~(^{ebus.ebusData, ebus.ebusParity});
`else
    logic w_unused_parity;
    assign w_unused_parity = ebus.ebusParity;
`endif

    // Snapshot sequencer: arbitration, per-word settle/capture, completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_S_IDLE;
            r_pending  <= '0;
            r_gcnt     <= '0;
            r_scnt     <= '0;
            r_ebus_req <= 1'b0;
            r_func     <= 1'b0;
            r_sel      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_valid    <= '0;
`ifdef EDP_DIAG_PARITY_EN
            r_perr     <= 1'b0;
            r_pmask    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_valid   <= '0;
                        r_timeout <= 1'b0;
`ifdef EDP_DIAG_PARITY_EN
                        r_perr    <= 1'b0;
                        r_pmask   <= '0;
`endif
                        if (|regMask) begin
                            r_pending  <= regMask;
                            r_busy     <= 1'b1;
                            r_ebus_req <= 1'b1;
                            r_gcnt     <= '0;
                            r_state    <= c_S_REQ;
                        end else begin
                            // Empty mask: report completion without touching the bus.
                            r_done <= 1'b1;
                        end
                    end
                end

                c_S_REQ: begin
                    if (ebus.ebusGrant) begin
                        r_sel   <= f_lowest(r_pending);
                        r_scnt  <= c_SETTLE;
                        r_func  <= 1'b1;
                        r_state <= c_S_DRIVE;
                    end else if (w_gcnt_next == c_GRANT_TO) begin
                        r_timeout  <= 1'b1;
                        r_ebus_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= c_S_FINISH;
                    end else begin
                        r_gcnt <= w_gcnt_next;
                    end
                end

                c_S_DRIVE: begin
                    if (r_scnt <= 4'd1) begin
                        r_state <= c_S_CAPTURE;
                    end else begin
                        r_scnt <= r_scnt - 4'd1;
                    end
                end

                c_S_CAPTURE: begin
                    r_valid[r_sel] <= 1'b1;
                    r_pending      <= w_pend_after;
`ifdef EDP_DIAG_PARITY_EN
                    if (w_par_bad) begin
                        r_pmask[r_sel] <= 1'b1;
                        r_perr         <= 1'b1;
                    end
`endif
                    if (|w_pend_after) begin
                        // Bus is kept: move straight on to the next select.
                        r_sel   <= f_lowest(w_pend_after);
                        r_scnt  <= c_SETTLE;
                        r_state <= c_S_DRIVE;
                    end else begin
                        r_func     <= 1'b0;
                        r_ebus_req <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= c_S_FINISH;
                    end
                end

                c_S_FINISH: begin
                    r_state <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Snapshot buffer; contents are only meaningful where validMask is set.
    always_ff @(posedge clk) begin
        if (w_cap_we) begin
            r_buf[r_sel] <= ebus.ebusData;
        end
    end

    assign ebus.ebusReq         = r_ebus_req;
    assign ebus.diagReadFunc12x = r_func;
    assign ebus.diagSel         = r_sel;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign timeout              = r_timeout;
    assign validMask            = r_valid;
    assign rdData               = r_buf[rdAddr];
`ifdef EDP_DIAG_PARITY_EN
    assign parityErr            = r_perr;
    assign parityMask           = r_pmask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edp_diag_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_edp_diag_reader
// Description : Self-checking bench for edp_diag_reader. An EDP register
//               model drives the EBUS from diagSel; expected snapshots,
//               latencies and select order come from the sequencing rules.
//               Honours EDP_DIAG_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edp_diag_reader;

    localparam int c_SETTLE   = 2;
    localparam int c_GRANT_TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [0:7]  regMask = '0;
    logic        busy, done, timeout;
    logic [0:7]  validMask;
    logic [2:0]  rdAddr = '0;
    logic [0:35] rdData;
`ifdef EDP_DIAG_PARITY_EN
    logic        parityErr;
    logic [0:7]  parityMask;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:35] edp_regs [0:7];
    logic        par_inject = 1'b0;
    logic [2:0]  par_bad_sel = 3'd0;

    edp_diag_reader_if bus ();

    // EDP side: selected register on the bus while read function 12x is driven.
    assign bus.ebusData   = bus.diagReadFunc12x ? edp_regs[bus.diagSel] : 36'h0;
    assign bus.ebusParity = ~(^bus.ebusData) ^ (par_inject && (bus.diagSel == par_bad_sel));

    edp_diag_reader #(
        .SETTLE_CYCLES (c_SETTLE),
        .GRANT_TIMEOUT (c_GRANT_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .regMask   (regMask),
        .ebus      (bus),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .validMask (validMask),
        .rdAddr    (rdAddr),
        .rdData    (rdData)
`ifdef EDP_DIAG_PARITY_EN
        ,
        .parityErr (parityErr),
        .parityMask(parityMask)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] rand36();
        logic [3:0]  hi;
        logic [31:0] lo;
        hi = 4'($urandom);
        lo = $urandom;
        return {hi, lo};
    endfunction

    // One snapshot: start at a negedge, watch the bus until done, then check.
    task automatic run_seq(input logic [0:7] mask, input int gdelay,
                           input int restart_at, input logic expect_to);
        int n, lat, reqc, funcc, exp_lat, exp_req;
        logic seen_done;
        logic [2:0] seq[$];
        logic [2:0] exp_seq[$];
        logic [0:7] exp_valid;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            edp_regs[k] = rand36();
            if (mask[k]) begin
                n++;
                exp_seq.push_back(3'(k));
            end
        end
        @(negedge clk);
        start = 1'b1;
        regMask = mask;
        bus.ebusGrant = 1'b0;
        @(negedge clk);
        start = 1'b0;
        regMask = ~mask;
        lat = 1; reqc = 0; funcc = 0; seen_done = 1'b0;
        chk("valid_cleared_on_start", 64'(validMask), 64'(0));
        chk("busy_after_start", 64'(busy), 64'(mask != 0));
        while (lat <= 300) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus.ebusReq) reqc++;
            if (bus.diagReadFunc12x) begin
                funcc++;
                if (seq.size() == 0 || seq[$] != bus.diagSel) seq.push_back(bus.diagSel);
            end
            bus.ebusGrant = !expect_to && (lat >= 1 + gdelay);
            if (lat == restart_at) begin
                start = 1'b1;
                regMask = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        bus.ebusGrant = 1'b0;
        chk("done_seen", 64'(seen_done), 64'(1));
        if (mask == 0) begin
            exp_lat = 1; exp_req = 0;
        end else if (expect_to) begin
            exp_lat = c_GRANT_TO + 1; exp_req = c_GRANT_TO;
        end else begin
            exp_req = 1 + gdelay + n * (c_SETTLE + 1);
            exp_lat = exp_req + 1;
        end
        chk("done_latency", 64'(lat), 64'(exp_lat));
        chk("ebusReq_cycles", 64'(reqc), 64'(exp_req));
        chk("func12x_cycles", 64'(funcc), 64'(expect_to ? 0 : n * (c_SETTLE + 1)));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("timeout_flag", 64'(timeout), 64'(expect_to));
        exp_valid = expect_to ? 8'h00 : mask;
        chk("validMask", 64'(validMask), 64'(exp_valid));
`ifdef EDP_DIAG_PARITY_EN
        chk("parityErr", 64'(parityErr),
            64'(par_inject && !expect_to && mask[par_bad_sel]));
        chk("parityMask", 64'(parityMask),
            64'((par_inject && !expect_to && mask[par_bad_sel]) ? (8'h80 >> par_bad_sel) : 8'h00));
`endif
        if (!expect_to) begin
            chk("sel_count", 64'(seq.size()), 64'(n));
            for (int i = 0; i < n && i < seq.size(); i++) chk("sel_order", 64'(seq[i]), 64'(exp_seq[i]));
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("timeout_sticky", 64'(timeout), 64'(expect_to));
        for (int k = 0; k < 8; k++) begin
            if (exp_valid[k]) begin
                rdAddr = 3'(k);
                #1;
                chk("rdData", 64'(rdData), 64'(edp_regs[k]));
            end
        end
    endtask

    initial begin
        logic [0:7] m;
        bus.ebusGrant = 1'b0;
        for (int k = 0; k < 8; k++) edp_regs[k] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ebusReq", 64'(bus.ebusReq), 64'(0));
        chk("rst_func12x", 64'(bus.diagReadFunc12x), 64'(0));
        chk("rst_diagSel", 64'(bus.diagSel), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_validMask", 64'(validMask), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Full snapshot with immediate grant: 26 cycles start to done.
        run_seq(8'hFF, 0, -1, 1'b0);
        // Selects 0 and 2 with grant held off for 5 cycles.
        run_seq(8'b10100000, 5, -1, 1'b0);
        // Empty mask: done next cycle, no bus activity.
        run_seq(8'h00, 0, -1, 1'b0);
        // Grant never arrives.
        run_seq(8'b01000010, 0, -1, 1'b1);
        // Timeout must clear on the next accepted start.
        run_seq(8'b00000001, 2, -1, 1'b0);
        // Second start while busy is ignored.
        run_seq(8'b11010001, 1, 6, 1'b0);

`ifdef EDP_DIAG_PARITY_EN
        par_inject = 1'b1;
        par_bad_sel = 3'd3;
        run_seq(8'hFF, 0, -1, 1'b0);
        par_inject = 1'b0;
        run_seq(8'b00110000, 0, -1, 1'b0);
`endif

        // Randomised snapshots.
        for (int r = 0; r < 6; r++) begin
            m = 8'($urandom_range(255, 1));
            run_seq(m, int'($urandom_range(5, 0)), -1, 1'b0);
        end

        // Reset while DRIVE is in progress.
        @(negedge clk);
        start = 1'b1;
        regMask = 8'hFF;
        bus.ebusGrant = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !bus.diagReadFunc12x; i++) @(negedge clk);
        chk("func12x_before_reset", 64'(bus.diagReadFunc12x), 64'(1));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ebusReq", 64'(bus.ebusReq), 64'(0));
        chk("mid_rst_func12x", 64'(bus.diagReadFunc12x), 64'(0));
        chk("mid_rst_diagSel", 64'(bus.diagSel), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_validMask", 64'(validMask), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst_req", 64'(bus.ebusReq), 64'(0));
        bus.ebusGrant = 1'b0;
        run_seq(8'b01111110, 3, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
